// File: rtl/mac.sv
`default_nettype none
// ============================================================================
// mac : transmit-only Ethernet II / IPv4 / UDP framer driving a 100M RMII PHY
// Revision: 1.0 - initial release
// ============================================================================
module mac #(
   parameter logic [15:0] UDP_MY_PORT = 16'd11451,
   parameter logic [15:0] UDP_PORT    = 16'd11451,
   parameter logic [31:0] SRC_IP_ADR  = {8'd192, 8'd168, 8'd15, 8'd14},
   parameter logic [31:0] DST_IP_ADR  = {8'd192, 8'd168, 8'd15, 8'd15},
   parameter logic [47:0] MAC_ADR     = 48'h06_00_AA_BB_0C_DD,
   parameter logic [47:0] MAC_MY_ADR  = 48'hE8_6A_64_FA_D1_7B
) (
   input  logic        I_clk50m,
   input  logic        I_rst,
   input  logic        I_en,
   input  logic [7:0]  I_data,
   input  logic [15:0] I_dataLen,
   input  logic [15:0] I_ipv4sign,
   output logic [1:0]  O_txd,
   output logic        O_txen,
   output logic        O_busy,
   output logic        O_isLoadData
);

   typedef enum logic [3:0] {
      S_IDLE     = 4'd0,
      S_PREAMBLE = 4'd1,
      S_ETH_HDR  = 4'd2,
      S_IP_HDR   = 4'd3,
      S_UDP_HDR  = 4'd4,
      S_PAYLOAD  = 4'd5,
      S_PAD      = 4'd6,
      S_FCS      = 4'd7,
      S_IFG      = 4'd8
   } state_t;

   localparam logic [10:0] MAX_LEN = 11'd1472;
   localparam logic [10:0] MIN_LEN = 11'd18;

   state_t      state_q, state_d;
   logic [10:0] cnt_q, cnt_d;
   logic [1:0]  dib_q, dib_d;
   logic [10:0] len_q, len_d;
   logic [15:0] sign_q, sign_d;
   logic [15:0] csum_q, csum_d;
   logic [31:0] crc_q, crc_d;
   logic [7:0]  data_q, data_d;

   logic [15:0]  total_len, udp_len;
   logic [19:0]  hdr_sum;
   logic [16:0]  fold1;
   logic [15:0]  fold2;
   logic [111:0] eth_hdr;
   logic [159:0] ip_hdr;
   logic [63:0]  udp_hdr;
   logic [31:0]  fcs;
   logic [7:0]   cur_byte;
   logic         last_byte;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'd0, b};
      for (int k = 0; k < 8; k++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
      end
      return r;
   endfunction

   assign total_len = 16'd28 + {5'd0, len_q};
   assign udp_len   = 16'd8 + {5'd0, len_q};

   // Header words with the checksum slot as zero; folded twice so the carry settles.
   assign hdr_sum = {4'd0, 16'h4500} + {4'd0, total_len} + {4'd0, sign_q} +
                    {4'd0, 16'h4000} + {4'd0, 16'h4011} +
                    {4'd0, SRC_IP_ADR[31:16]} + {4'd0, SRC_IP_ADR[15:0]} +
                    {4'd0, DST_IP_ADR[31:16]} + {4'd0, DST_IP_ADR[15:0]};
   assign fold1   = {1'b0, hdr_sum[15:0]} + {13'd0, hdr_sum[19:16]};
   assign fold2   = fold1[15:0] + {15'd0, fold1[16]};

   assign eth_hdr = {MAC_ADR, MAC_MY_ADR, 16'h0800};
   assign ip_hdr  = {16'h4500, total_len, sign_q, 16'h4000, 16'h4011, csum_q,
                     SRC_IP_ADR, DST_IP_ADR};
   assign udp_hdr = {UDP_MY_PORT, UDP_PORT, udp_len, 16'h0000};
   assign fcs     = ~crc_q;

   always_comb begin
      cur_byte  = 8'h00;
      last_byte = 1'b0;
      case (state_q)
         S_PREAMBLE: begin
            cur_byte  = (cnt_q == 11'd7) ? 8'hD5 : 8'h55;
            last_byte = (cnt_q == 11'd7);
         end
         S_ETH_HDR: begin
            cur_byte  = eth_hdr[(7'd104 - {cnt_q[3:0], 3'b000}) +: 8];
            last_byte = (cnt_q == 11'd13);
         end
         S_IP_HDR: begin
            cur_byte  = ip_hdr[(8'd152 - {cnt_q[4:0], 3'b000}) +: 8];
            last_byte = (cnt_q == 11'd19);
         end
         S_UDP_HDR: begin
            cur_byte  = udp_hdr[(6'd56 - {cnt_q[2:0], 3'b000}) +: 8];
            last_byte = (cnt_q == 11'd7);
         end
         S_PAYLOAD: begin
            // First dibit goes straight from the source; the rest from the captured copy.
            cur_byte  = (dib_q == 2'd0) ? I_data : data_q;
            last_byte = (cnt_q == len_q - 11'd1);
         end
         S_PAD: begin
            last_byte = (cnt_q == MIN_LEN - 11'd1 - len_q);
         end
         S_FCS: begin
            cur_byte  = fcs[{cnt_q[1:0], 3'b000} +: 8];
            last_byte = (cnt_q == 11'd3);
         end
         S_IFG: begin
            last_byte = (cnt_q == 11'd11);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dib_d   = dib_q;
      len_d   = len_q;
      sign_d  = sign_q;
      csum_d  = csum_q;
      crc_d   = crc_q;
      data_d  = data_q;

      if (state_q == S_IDLE) begin
         if (I_en) begin
            state_d = S_PREAMBLE;
            len_d   = (I_dataLen > {5'd0, MAX_LEN}) ? MAX_LEN : I_dataLen[10:0];
            sign_d  = I_ipv4sign;
            cnt_d   = 11'd0;
            dib_d   = 2'd0;
            crc_d   = 32'hFFFF_FFFF;
         end
      end else begin
         dib_d = dib_q + 2'd1;
         if (dib_q == 2'd3) begin
            cnt_d = last_byte ? 11'd0 : cnt_q + 11'd1;
            if (last_byte) begin
               case (state_q)
                  S_PREAMBLE: state_d = S_ETH_HDR;
                  S_ETH_HDR:  state_d = S_IP_HDR;
                  S_IP_HDR:   state_d = S_UDP_HDR;
                  S_UDP_HDR:  state_d = (len_q == 11'd0) ? S_PAD : S_PAYLOAD;
                  S_PAYLOAD:  state_d = (len_q < MIN_LEN) ? S_PAD : S_FCS;
                  S_PAD:      state_d = S_FCS;
                  S_FCS:      state_d = S_IFG;
                  default:    state_d = S_IDLE;
               endcase
            end
            if (state_q inside {S_ETH_HDR, S_IP_HDR, S_UDP_HDR, S_PAYLOAD, S_PAD}) begin
               crc_d = crc_byte(crc_q, cur_byte);
            end
         end
      end

      if (state_q == S_PREAMBLE) begin
         csum_d = ~fold2;
      end
      if (state_q == S_PAYLOAD && dib_q == 2'd0) begin
         data_d = I_data;
      end
   end

   always_ff @(posedge I_clk50m) begin
      if (I_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 11'd0;
         dib_q   <= 2'd0;
         len_q   <= 11'd0;
         sign_q  <= 16'd0;
         csum_q  <= 16'd0;
         crc_q   <= 32'hFFFF_FFFF;
         data_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dib_q   <= dib_d;
         len_q   <= len_d;
         sign_q  <= sign_d;
         csum_q  <= csum_d;
         crc_q   <= crc_d;
         data_q  <= data_d;
      end
   end

   assign O_busy       = (state_q != S_IDLE);
   assign O_txen       = O_busy && (state_q != S_IFG);
   assign O_txd        = O_txen ? cur_byte[{dib_q, 1'b0} +: 2] : 2'b00;
   assign O_isLoadData = (state_q == S_PAYLOAD) && (dib_q == 2'd0);

endmodule
`default_nettype wire

// File: tb/tb_mac.sv
`default_nettype none
// ============================================================================
// tb_mac : directed + randomized frames checked against a byte-level frame model
// Revision: 1.0 - initial release
// ============================================================================
module tb_mac;

   logic        clk = 1'b0;
   logic        rst, en;
   logic [7:0]  data;
   logic [15:0] dlen, sign;
   logic [1:0]  txd;
   logic        txen, busy, ld;

   always #10 clk = ~clk;

   mac dut (
      .I_clk50m    (clk),
      .I_rst       (rst),
      .I_en        (en),
      .I_data      (data),
      .I_dataLen   (dlen),
      .I_ipv4sign  (sign),
      .O_txd       (txd),
      .O_txen      (txen),
      .O_busy      (busy),
      .O_isLoadData(ld)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0]  pl [1472];
   logic [7:0]  exp_q [$];
   logic [15:0] exp_cs;
   logic [31:0] exp_fcs;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Whole frame as a byte list: preamble, headers, payload, padding, FCS.
   task automatic build_expected(input int len, input logic [15:0] id);
      logic [7:0]  eth [14] = '{8'h06, 8'h00, 8'hAA, 8'hBB, 8'h0C, 8'hDD,
                                8'hE8, 8'h6A, 8'h64, 8'hFA, 8'hD1, 8'h7B,
                                8'h08, 8'h00};
      logic [7:0]  ip [20];
      logic [7:0]  udp [8];
      logic [15:0] tl, ul;
      logic [31:0] crc;
      int          s;
      bit          fb;
      tl = 16'(28 + len);
      ul = 16'(8 + len);
      ip = '{8'h45, 8'h00, tl[15:8], tl[7:0], id[15:8], id[7:0], 8'h40, 8'h00,
             8'h40, 8'h11, 8'h00, 8'h00, 8'd192, 8'd168, 8'd15, 8'd14,
             8'd192, 8'd168, 8'd15, 8'd15};
      s = 0;
      for (int i = 0; i < 10; i++) s += int'({ip[2*i], ip[2*i+1]});
      while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >>> 16);
      exp_cs = ~s[15:0];
      ip[10] = exp_cs[15:8];
      ip[11] = exp_cs[7:0];
      udp = '{8'h2C, 8'hBB, 8'h2C, 8'hBB, ul[15:8], ul[7:0], 8'h00, 8'h00};
      exp_q = {};
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      for (int i = 0; i < 14; i++) exp_q.push_back(eth[i]);
      for (int i = 0; i < 20; i++) exp_q.push_back(ip[i]);
      for (int i = 0; i < 8; i++)  exp_q.push_back(udp[i]);
      for (int i = 0; i < len; i++) exp_q.push_back(pl[i]);
      for (int i = len; i < 18; i++) exp_q.push_back(8'h00);
      crc = 32'hFFFF_FFFF;
      for (int i = 8; i < exp_q.size(); i++) begin
         for (int k = 0; k < 8; k++) begin
            fb  = crc[0] ^ exp_q[i][k];
            crc = crc >> 1;
            if (fb) crc = crc ^ 32'hEDB8_8320;
         end
      end
      exp_fcs = ~crc;
      for (int i = 0; i < 4; i++) exp_q.push_back(exp_fcs[8*i +: 8]);
   endtask

   task automatic run_frame(input int len_req, input logic [15:0] id, input bit rnd,
                            input bit chained, input bit hold, input bit noise,
                            input string nm);
      int eff, budget, busy_len, n;
      int bc = 0, txc = 0, rises = 0, strobes = 0, gapbad = 0, ifgbad = 0;
      int last_strobe = -1, nd = 0, idx = 0, nb = 0;
      bit prev_txen = 0, timed_out = 1, adv;
      logic [7:0] cur = 8'h00;
      logic [7:0] cap [$];
      eff = (len_req > 1472) ? 1472 : len_req;
      for (int i = 0; i < eff; i++) pl[i] = rnd ? 8'($urandom) : 8'(i + (len_req == 4 ? 1 : 0));
      build_expected(eff, id);
      busy_len = 4 * exp_q.size() + 48;
      budget   = busy_len + 20;
      if (!chained) begin
         @(posedge clk); #1;
         en   = 1'b1;
         dlen = 16'(len_req);
         sign = id;
      end
      data = pl[0];
      @(posedge clk); #1;
      en = hold;
      for (int cyc = 0; cyc < budget; cyc++) begin
         @(negedge clk);
         if (cyc == 0) check({nm, " start_latency"}, {31'd0, busy & txen}, 32'd1);
         if (!busy) begin
            timed_out = 0;
            break;
         end
         bc++;
         if (txen) begin
            txc++;
            if (!prev_txen) rises++;
            cur[2*nd +: 2] = txd;
            nd++;
            if (nd == 4) begin
               cap.push_back(cur);
               nd = 0;
            end
         end else if (txd != 2'b00) begin
            ifgbad++;
         end
         prev_txen = txen;
         adv = ld;
         if (ld) begin
            strobes++;
            if (last_strobe >= 0 && cyc - last_strobe != 4) gapbad++;
            last_strobe = cyc;
         end
         @(posedge clk); #1;
         if (adv) begin
            idx++;
            data = (idx < eff) ? pl[idx] : 8'($urandom);
         end
         if (noise) en = (cyc < busy_len - 4) ? 1'($urandom) : 1'b0;
      end
      check({nm, " timeout"}, {31'd0, timed_out}, 32'd0);
      check({nm, " txen_clocks"}, txc, 4 * exp_q.size());
      check({nm, " busy_clocks"}, bc, busy_len);
      check({nm, " txen_rises"}, rises, 1);
      check({nm, " ifg_txd_nonzero"}, ifgbad, 0);
      check({nm, " strobes"}, strobes, eff);
      check({nm, " strobe_spacing_errs"}, gapbad, 0);
      check({nm, " byte_count"}, cap.size(), exp_q.size());
      for (int i = 0; i < cap.size() && i < exp_q.size(); i++) if (cap[i] !== exp_q[i]) nb++;
      check({nm, " byte_errs"}, nb, 0);
      if (cap.size() == exp_q.size()) begin
         n = cap.size();
         check({nm, " ip_total_len"}, {16'd0, cap[24], cap[25]}, 28 + eff);
         check({nm, " ip_id"}, {16'd0, cap[26], cap[27]}, {16'd0, id});
         check({nm, " ip_csum"}, {16'd0, cap[32], cap[33]}, {16'd0, exp_cs});
         check({nm, " udp_len"}, {16'd0, cap[46], cap[47]}, 8 + eff);
         check({nm, " fcs"}, {cap[n-1], cap[n-2], cap[n-3], cap[n-4]}, exp_fcs);
      end
   endtask

   initial begin
      rst  = 1'b1;
      en   = 1'b0;
      data = 8'h00;
      dlen = 16'd0;
      sign = 16'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset txd", {30'd0, txd}, 32'd0);
      check("reset txen", {31'd0, txen}, 32'd0);
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset load", {31'd0, ld}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_frame(4, 16'h0123, 1'b0, 1'b0, 1'b0, 1'b0, "len4");
      run_frame(100, 16'h4A5B, 1'b0, 1'b0, 1'b0, 1'b0, "len100");
      run_frame(0, 16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, "len0");
      run_frame(17, 16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, "len17");
      run_frame(18, 16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, "len18");
      run_frame($urandom_range(60, 1), 16'($urandom), 1'b1, 1'b0, 1'b0, 1'b1, "rand_noise");
      run_frame(20, 16'h7777, 1'b1, 1'b0, 1'b1, 1'b0, "b2b_first");
      run_frame(20, 16'h7777, 1'b1, 1'b1, 1'b0, 1'b0, "b2b_second");

      // Abort a frame with reset partway through the payload.
      @(posedge clk); #1;
      en   = 1'b1;
      dlen = 16'd50;
      sign = 16'h1234;
      @(posedge clk); #1;
      en = 1'b0;
      repeat (300) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("midreset txen", {31'd0, txen}, 32'd0);
      check("midreset busy", {31'd0, busy}, 32'd0);
      check("midreset load", {31'd0, ld}, 32'd0);
      check("midreset txd", {30'd0, txd}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_frame(33, 16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, "after_reset");

      run_frame(1472, 16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, "len1472");
      run_frame(2000, 16'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, "len2000");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
